// File: rtl/gf251_rej_pack_32.sv
// gf251_rej_pack_32: rejection sampler that packs four GF(251) elements per 32-bit word.
// Raw random bytes >= 251 are dropped. Accepted bytes are compacted into a 7-byte
// staging buffer, and lanes 0..3 are emitted as one output word.
// Optional build macro GF251_REJ_STATS_EN adds o_rej_cnt, the rejected-byte count
// for the current run.
module gf251_rej_pack_32 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic [31:0]      i_rand_data,
  input  logic             i_rand_valid,
  output logic             o_rand_ready,
  output logic [31:0]      o_x,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_done
`ifdef GF251_REJ_STATS_EN
  ,
  output logic [15:0]      o_rej_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // words not yet loaded into o_x
  logic [7:0]       stage_q [7];
  logic [7:0]       stage_d [7];
  logic [2:0]       fill_q, fill_d;
  logic [31:0]      x_q, x_d;
  logic             valid_q, valid_d;

  logic             to_load, need_more, load, in_fire;
  logic [2:0]       rej_bytes;

  // Handshake decode. Input is requested only while staged bytes cannot cover
  // the remaining words, so no surplus word is pulled in at the end of a run.
  always_comb begin
    to_load      = (state_q == StRun) && (cnt_q != '0);
    need_more    = {cnt_q, 2'b00} > {{(CNT_W-1){1'b0}}, fill_q};
    load         = to_load && (fill_q >= 3'd4) && (!valid_q || i_ready);
    o_rand_ready = to_load && need_more && ((fill_q <= 3'd3) || load);
    in_fire      = o_rand_ready && i_rand_valid;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_start) state_d = (i_count == '0) ? StDone : StRun;
      StRun:  if ((cnt_q == '0) && valid_q && i_ready) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Staging buffer: shift out a loaded word first, then append accepted bytes.
  always_comb begin
    for (int i = 0; i < 7; i++) stage_d[i] = stage_q[i];
    fill_d    = fill_q;
    rej_bytes = 3'd0;
    if (load) begin
      stage_d[0] = stage_q[4];
      stage_d[1] = stage_q[5];
      stage_d[2] = stage_q[6];
      stage_d[3] = 8'h00;
      stage_d[4] = 8'h00;
      stage_d[5] = 8'h00;
      stage_d[6] = 8'h00;
      fill_d     = fill_q - 3'd4;
    end
    if (in_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (i_rand_data[8*b +: 8] < 8'd251) begin
          for (int j = 0; j < 7; j++) begin
            if (fill_d == 3'(j)) stage_d[j] = i_rand_data[8*b +: 8];
          end
          fill_d = fill_d + 3'd1;
        end else begin
          rej_bytes = rej_bytes + 3'd1;
        end
      end
    end
    // Leftovers are discarded when the run ends or a new run starts.
    if ((state_q == StIdle && i_start) || (state_q == StRun && state_d == StDone)) begin
      fill_d = 3'd0;
      for (int i = 0; i < 7; i++) stage_d[i] = 8'h00;
    end
  end

  // Output word register and remaining-word counter.
  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    valid_d = valid_q;
    if (state_q == StIdle && i_start) cnt_d = i_count;
    if (load) begin
      cnt_d   = cnt_q - 1'b1;
      x_d     = {stage_q[3], stage_q[2], stage_q[1], stage_q[0]};
      valid_d = 1'b1;
    end else if (i_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fill_q  <= 3'd0;
      x_q     <= 32'h0;
      valid_q <= 1'b0;
      for (int i = 0; i < 7; i++) stage_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      for (int i = 0; i < 7; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign o_x     = x_q;
  assign o_valid = valid_q;
  assign o_done  = (state_q == StDone);

`ifdef GF251_REJ_STATS_EN
  logic [15:0] rej_q, rej_d;
  logic [16:0] rej_sum;

  // Saturating rejected-byte counter, cleared on start and held after the run.
  always_comb begin
    rej_sum = {1'b0, rej_q} + {14'h0, rej_bytes};
    rej_d   = rej_q;
    if (state_q == StIdle && i_start) rej_d = 16'h0;
    else if (in_fire) rej_d = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rej_q <= 16'h0;
    else          rej_q <= rej_d;
  end

  assign o_rej_cnt = rej_q;
`endif

endmodule

// File: tb/tb_gf251_rej_pack_32.sv
// Directed self-checking bench for gf251_rej_pack_32.
module tb_gf251_rej_pack_32;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [15:0] i_count;
  logic [31:0] i_rand_data;
  logic        i_rand_valid;
  logic        o_rand_ready;
  logic [31:0] o_x;
  logic        o_valid;
  logic        i_ready;
  logic        o_done;
`ifdef GF251_REJ_STATS_EN
  logic [15:0] o_rej_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] in_w  [8];
  logic [31:0] exp_w [4];
  logic [7:0]  rr_e, val_e, done_e;

  always #5 i_clk = ~i_clk;

  gf251_rej_pack_32 #(.CNT_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_count      (i_count),
    .i_rand_data  (i_rand_data),
    .i_rand_valid (i_rand_valid),
    .o_rand_ready (o_rand_ready),
    .o_x          (o_x),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_done       (o_done)
`ifdef GF251_REJ_STATS_EN
    ,
    .o_rej_cnt    (o_rej_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Starts a run, feeds in_w[0..n_in-1] whenever requested, collects handshaken
  // words and compares them with exp_w. Holds i_ready low for 'stall' cycles
  // once the first word is valid.
  task automatic run(input string tag, input int cnt, input int n_in, input int n_exp,
                     input int exp_cons, input int stall, input int exp_rej);
    int   idx;
    int   got;
    int   stall_left;
    logic seen_done;
    idx        = 0;
    got        = 0;
    stall_left = stall;
    seen_done  = 1'b0;
    i_count    = 16'(cnt);
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      i_rand_valid = (idx < n_in);
      i_rand_data  = (idx < n_in) ? in_w[idx] : 32'h0;
      i_ready      = !(o_valid && stall_left > 0);
      #1;
      if (!i_ready) begin
        chk({tag, "_stall_x"}, o_x, exp_w[got]);
        chk({tag, "_stall_rr"}, {31'h0, o_rand_ready}, 32'h0);
        stall_left--;
      end
      if (o_done) seen_done = 1'b1;
      if (i_rand_valid && o_rand_ready) idx++;
      if (o_valid && i_ready) begin
        if (got < n_exp) chk($sformatf("%s_word%0d", tag, got), o_x, exp_w[got]);
        else chk({tag, "_extra_word"}, o_x, 32'hxxxxxxxx);
        got++;
      end
      tick();
    end
    i_rand_valid = 1'b0;
    i_ready      = 1'b1;
    chk({tag, "_done_seen"}, {31'h0, seen_done}, 32'h1);
    chk({tag, "_nwords"}, 32'(got), 32'(n_exp));
    chk({tag, "_consumed"}, 32'(idx), 32'(exp_cons));
`ifdef GF251_REJ_STATS_EN
    chk({tag, "_rej"}, {16'h0, o_rej_cnt}, 32'(exp_rej));
`else
    if (exp_rej < 0) $display("note: negative reject count");
`endif
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_count      = 16'h0;
    i_rand_data  = 32'h0;
    i_rand_valid = 1'b0;
    i_ready      = 1'b1;
    #12;
    chk("rst_x", o_x, 32'h0);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_rr", {31'h0, o_rand_ready}, 32'h0);
    chk("rst_done", {31'h0, o_done}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // Mixed accept/reject; trailing 0x04 is discarded, third word never requested.
    in_w[0]  = 32'hFFFB0201;
    in_w[1]  = 32'h04FA03FC;
    in_w[2]  = 32'h55555555;
    exp_w[0] = 32'hFA030201;
    run("t1", 1, 3, 1, 2, 0, 3);

    // All-accept stream at full rate.
    rr_e   = 8'b00001111;
    val_e  = 8'b00111100;
    done_e = 8'b01000000;
    i_rand_data  = 32'h0;
    i_rand_valid = 1'b1;
    i_ready      = 1'b1;
    i_count      = 16'd4;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_rr%0d", i), {31'h0, o_rand_ready}, {31'h0, rr_e[i]});
      chk($sformatf("t2_valid%0d", i), {31'h0, o_valid}, {31'h0, val_e[i]});
      chk($sformatf("t2_done%0d", i), {31'h0, o_done}, {31'h0, done_e[i]});
      if (val_e[i]) chk($sformatf("t2_x%0d", i), o_x, 32'h0);
      tick();
    end
    i_rand_valid = 1'b0;

    // Fully rejected words are consumed without changing the fill.
    in_w[0]  = 32'hFFFFFFFF;
    in_w[1]  = 32'hFFFFFFFF;
    in_w[2]  = 32'hFFFFFFFF;
    in_w[3]  = 32'hFAFAFAFA;
    in_w[4]  = 32'hFAFAFAFA;
    in_w[5]  = 32'h12345678;
    exp_w[0] = 32'hFAFAFAFA;
    exp_w[1] = 32'hFAFAFAFA;
    run("t3", 2, 6, 2, 5, 0, 12);

    // Downstream back-pressure: word held, input stops, order preserved.
    in_w[0]  = 32'h03020100;
    in_w[1]  = 32'h07060504;
    in_w[2]  = 32'h0B0A0908;
    in_w[3]  = 32'h0F0E0D0C;
    in_w[4]  = 32'h13121110;
    exp_w[0] = 32'h03020100;
    exp_w[1] = 32'h07060504;
    exp_w[2] = 32'h0B0A0908;
    run("t4", 3, 5, 3, 3, 5, 0);

    // Zero-length run: straight to DONE, nothing consumed.
    i_rand_valid = 1'b1;
    i_rand_data  = 32'h01020304;
    i_count      = 16'd0;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t5_done", {31'h0, o_done}, 32'h1);
    chk("t5_rr", {31'h0, o_rand_ready}, 32'h0);
    tick();
    chk("t5_done_clr", {31'h0, o_done}, 32'h0);
    chk("t5_rr_idle", {31'h0, o_rand_ready}, 32'h0);
    i_rand_valid = 1'b0;

    // Start ignored mid-run, then asynchronous reset mid-run.
    i_rand_data  = 32'h01010101;
    i_rand_valid = 1'b1;
    i_ready      = 1'b0;
    i_count      = 16'd2;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_rand_valid = 1'b0;
    tick();
    chk("t6_valid", {31'h0, o_valid}, 32'h1);
    chk("t6_x", o_x, 32'h01010101);
    i_count = 16'd0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t6_start_ignored", {31'h0, o_done}, 32'h0);
    chk("t6_still_valid", {31'h0, o_valid}, 32'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_x", o_x, 32'h0);
    chk("t6_rst_valid", {31'h0, o_valid}, 32'h0);
    chk("t6_rst_rr", {31'h0, o_rand_ready}, 32'h0);
    chk("t6_rst_done", {31'h0, o_done}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    in_w[0]  = 32'h11223344;
    exp_w[0] = 32'h11223344;
    run("t7", 1, 1, 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
